// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between two requesters.
// Optional grant statistics counters are enabled with `define ROM_ARB_STATS_EN.
module rom_read_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [7:0]        rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [7:0]        rdata1,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
`endif
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

    pri_e              pri_q, pri_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ROM_LAT:0]  tag_vld_q, tag_vld_d;
    logic [ROM_LAT:0]  tag_own_q, tag_own_d;
    logic [7:0]        rdata0_q, rdata0_d;
    logic [7:0]        rdata1_q, rdata1_d;
    logic              ret_vld;
    logic              ret_own;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pri_d = pri_q;
        if (reset_n) begin
            if (req0 && (!req1 || pri_q == PRI0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            pri_d = PRI1;
        end else if (gnt1) begin
            pri_d = PRI0;
        end
    end

    assign rom_rd = gnt0 | gnt1;

    // When idle the bus keeps showing the last issued address rather than
    // following whatever the requesters happen to drive.
    always_comb begin
        rom_addr = last_addr_q;
        if (!reset_n) begin
            rom_addr = '0;
        end else if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

    assign last_addr_d = rom_rd ? rom_addr : last_addr_q;

    // Stage k holds the owner of the read issued k+1 cycles ago; the stage
    // before the last marks the cycle in which rom_q carries that read's data.
    assign tag_vld_d = {tag_vld_q[ROM_LAT-1:0], rom_rd};
    assign tag_own_d = {tag_own_q[ROM_LAT-1:0], gnt1};
    assign ret_vld   = tag_vld_q[ROM_LAT-1];
    assign ret_own   = tag_own_q[ROM_LAT-1];

    assign rdata0_d = (ret_vld && !ret_own) ? rom_q : rdata0_q;
    assign rdata1_d = (ret_vld &&  ret_own) ? rom_q : rdata1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q       <= PRI0;
            last_addr_q <= '0;
            tag_vld_q   <= '0;
            tag_own_q   <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            pri_q       <= pri_d;
            last_addr_q <= last_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_own_q   <= tag_own_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign rvalid0 = tag_vld_q[ROM_LAT] & ~tag_own_q[ROM_LAT];
    assign rvalid1 = tag_vld_q[ROM_LAT] &  tag_own_q[ROM_LAT];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

    assign gnt_cnt0_d = (gnt0 && gnt_cnt0_q != '1) ? gnt_cnt0_q + 16'd1 : gnt_cnt0_q;
    assign gnt_cnt1_d = (gnt1 && gnt_cnt1_q != '1) ? gnt_cnt1_q + 16'd1 : gnt_cnt1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed, table-driven bench for rom_read_arbiter with a one-cycle ROM model.
// Stats checks compile in when ROM_ARB_STATS_EN is defined.
module tb_rom_read_arbiter;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset_n;
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [7:0]        rdata0, rdata1;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
`ifdef ROM_ARB_STATS_EN
    logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rom_read_arbiter #(.ADDR_W(ADDR_W), .ROM_LAT(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_q    (rom_q)
`ifdef ROM_ARB_STATS_EN
        ,
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rv(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    initial rom_q = 8'h00;
    always @(posedge clk) begin
        if (rom_rd) rom_q <= rv(int'(rom_addr));
    end

    typedef struct {
        logic       rst_n;
        logic       r0;
        logic [4:0] a0;
        logic       r1;
        logic [4:0] a1;
        logic       g0;
        logic       g1;
        logic       rd;
        logic [4:0] ra;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rst_n, input logic r0, input int a0,
                                input logic r1, input int a1, input logic g0,
                                input logic g1, input logic rd, input int ra,
                                input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1);
        vec_t v;
        v.rst_n = rst_n; v.r0 = r0; v.a0 = 5'(a0); v.r1 = r1; v.a1 = 5'(a1);
        v.g0 = g0; v.g1 = g1; v.rd = rd; v.ra = 5'(ra);
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic r0, input int a0,
                         input logic r1, input int a1);
        @(posedge clk);
        #1;
        reset_n = rst_n;
        req0    = r0;
        addr0   = 5'(a0);
        req1    = r1;
        addr1   = 5'(a1);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        #2 reset_n = 1'b0;

        //            rst r0 a0 r1 a1   g0 g1 rd ra  v0 d0      v1 d1
        vecs[0]  = mk(0, 1, 2, 1, 9,   0, 0, 0, 0,  0, 8'h00,  0, 8'h00);
        vecs[1]  = mk(0, 1, 2, 1, 9,   0, 0, 0, 0,  0, 8'h00,  0, 8'h00);
        vecs[2]  = mk(0, 1, 2, 1, 9,   0, 0, 0, 0,  0, 8'h00,  0, 8'h00);
        vecs[3]  = mk(1, 1, 2, 1, 9,   1, 0, 1, 2,  0, 8'h00,  0, 8'h00);
        vecs[4]  = mk(1, 1, 2, 1, 9,   0, 1, 1, 9,  0, 8'h00,  0, 8'h00);
        vecs[5]  = mk(1, 1, 2, 1, 9,   1, 0, 1, 2,  1, rv(2),  0, 8'h00);
        vecs[6]  = mk(1, 1, 2, 1, 9,   0, 1, 1, 9,  0, rv(2),  1, rv(9));
        vecs[7]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 9,  1, rv(2),  0, rv(9));
        vecs[8]  = mk(1, 1, 5, 0, 0,   1, 0, 1, 5,  0, rv(2),  1, rv(9));
        vecs[9]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 5,  0, rv(2),  0, rv(9));
        vecs[10] = mk(1, 0, 0, 0, 0,   0, 0, 0, 5,  1, rv(5),  0, rv(9));
        vecs[11] = mk(1, 1, 0, 0, 0,   1, 0, 1, 0,  0, rv(5),  0, rv(9));
        vecs[12] = mk(1, 1, 1, 0, 0,   1, 0, 1, 1,  0, rv(5),  0, rv(9));
        vecs[13] = mk(1, 1, 2, 0, 0,   1, 0, 1, 2,  1, rv(0),  0, rv(9));
        vecs[14] = mk(1, 1, 3, 0, 0,   1, 0, 1, 3,  1, rv(1),  0, rv(9));
        vecs[15] = mk(1, 0, 0, 0, 0,   0, 0, 0, 3,  1, rv(2),  0, rv(9));
        vecs[16] = mk(1, 0, 0, 0, 0,   0, 0, 0, 3,  1, rv(3),  0, rv(9));
        vecs[17] = mk(1, 1, 4, 1, 7,   0, 1, 1, 7,  0, rv(3),  0, rv(9));
        vecs[18] = mk(1, 0, 0, 0, 0,   0, 0, 0, 7,  0, rv(3),  0, rv(9));
        vecs[19] = mk(1, 0, 0, 0, 0,   0, 0, 0, 7,  0, rv(3),  1, rv(7));

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst_n, vecs[i].r0, int'(vecs[i].a0), vecs[i].r1, int'(vecs[i].a1));
            check($sformatf("v%0d gnt0", i),     16'(gnt0),     16'(vecs[i].g0));
            check($sformatf("v%0d gnt1", i),     16'(gnt1),     16'(vecs[i].g1));
            check($sformatf("v%0d rom_rd", i),   16'(rom_rd),   16'(vecs[i].rd));
            check($sformatf("v%0d rom_addr", i), 16'(rom_addr), 16'(vecs[i].ra));
            check($sformatf("v%0d rvalid0", i),  16'(rvalid0),  16'(vecs[i].v0));
            check($sformatf("v%0d rdata0", i),   16'(rdata0),   16'(vecs[i].d0));
            check($sformatf("v%0d rvalid1", i),  16'(rvalid1),  16'(vecs[i].v1));
            check($sformatf("v%0d rdata1", i),   16'(rdata1),   16'(vecs[i].d1));
        end

        // Reset with reads from both requesters in flight; priority was PRI1.
        drive(1, 0, 0, 1, 3);
        check("mid gnt1", 16'(gnt1), 16'd1);
        check("mid rom_addr", 16'(rom_addr), 16'd3);
        drive(1, 1, 6, 0, 0);
        check("mid gnt0", 16'(gnt0), 16'd1);
        drive(0, 1, 6, 1, 3);
        check("rst gnt0", 16'(gnt0), 16'd0);
        check("rst gnt1", 16'(gnt1), 16'd0);
        check("rst rom_rd", 16'(rom_rd), 16'd0);
        check("rst rom_addr", 16'(rom_addr), 16'd0);
        check("rst rvalid1", 16'(rvalid1), 16'd0);
        check("rst rdata1", 16'(rdata1), 16'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0);
            check($sformatf("post%0d rvalid0", k), 16'(rvalid0), 16'd0);
            check($sformatf("post%0d rvalid1", k), 16'(rvalid1), 16'd0);
            check($sformatf("post%0d rom_addr", k), 16'(rom_addr), 16'd0);
        end
        drive(1, 1, 1, 1, 2);
        check("post tie gnt0", 16'(gnt0), 16'd1);
        check("post tie gnt1", 16'(gnt1), 16'd0);
        drive(1, 1, 1, 1, 2);
        check("post tie2 gnt1", 16'(gnt1), 16'd1);
        drive(1, 0, 0, 0, 0);

`ifdef ROM_ARB_STATS_EN
        drive(0, 0, 0, 0, 0);
        check("cnt rst 0", gnt_cnt0, 16'd0);
        check("cnt rst 1", gnt_cnt1, 16'd0);
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 2, 0, 0);
        drive(1, 1, 3, 0, 0);
        check("cnt lag 0", gnt_cnt0, 16'd2);
        drive(1, 0, 0, 1, 4);
        drive(1, 0, 0, 1, 5);
        drive(1, 0, 0, 0, 0);
        check("cnt 0", gnt_cnt0, 16'd3);
        check("cnt 1", gnt_cnt1, 16'd2);
        force dut.gnt_cnt0_q = 16'hFFFF;
        #1;
        release dut.gnt_cnt0_q;
        drive(1, 1, 7, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("cnt sat 0", gnt_cnt0, 16'hFFFF);
        check("cnt sat 1", gnt_cnt1, 16'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    always @(negedge clk) begin
        if (rvalid0 && rvalid1) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_rvalid: got rvalid0=%b rvalid1=%b expected one-hot", rvalid0, rvalid1);
        end
    end

endmodule
